alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Combined ALU decode and execute stage for the RV32 pipeline (EX stage).
//  Decodes {funct7,funct3} under ALUOp into an internal op and executes it
//  with a registered output. MUL runs on an iterative multiplier.
//  Valid/ready handshakes on both sides let EX stall the pipeline while MUL runs.
// PARAMETERS
//  XLEN      32  datapath width; power of two, >= 8
//  MUL_STEP  1   multiplier bits retired per cycle; power of two, divides XLEN
// PORTS
//  clk_i      in   1     clock, rising edge
//  rst_i      in   1     reset, synchronous, active-high
//  valid_i    in   1     operation request
//  ready_o    out  1     unit can accept; transfer = valid_i & ready_o
//  ALUOp_i    in   2     00 ld/st add, 01 branch sub, 10 R-type, 11 I-type
//  funct_i    in   10    {funct7[6:0], funct3[2:0]}
//  src1_i     in   XLEN  operand A
//  src2_i     in   XLEN  operand B (immediate already extended for I-type)
//  valid_o    out  1     result_o/zero_o/illegal_o valid
//  ready_i    in   1     consumer accepts; transfer = valid_o & ready_i
//  result_o   out  XLEN  result
//  zero_o     out  1     result_o == 0 (branch compare)
//  illegal_o  out  1     op not decodable; result_o = 0
// BEHAVIOUR
//  Reset: state IDLE, valid_o=0, result_o=0, zero_o=0, illegal_o=0. Mid-MUL reset abandons the op.
//  Decode:
//   00 -> ADD for any funct.
//   01 -> SUB for any funct.
//   10 -> funct7 0000000 with funct3 000/001/010/011/100/101/110/111
//         = ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
//         funct7 0100000 with 000/101 = SUB/SRA.
//         funct7 0000001 with 000 = MUL (low XLEN bits).
//   11 -> funct3 000/010/011/100/110/111 = ADDI/SLTI/SLTIU/XORI/ORI/ANDI (funct7 ignored).
//         001 with funct7 0000000 = SLLI.
//         101 with funct7 0000000/0100000 = SRLI/SRAI.
//   Anything else is illegal: 1-cycle op, result 0, illegal_o=1. Never holds the previous value.
//  Arithmetic: wrap-around modulo 2^XLEN. Shift amount = src2_i[$clog2(XLEN)-1:0].
//   SLT/SLTI signed, SLTU/SLTIU unsigned, result 0 or 1.
//  ready_o = (state==IDLE) & (~valid_o | ready_i); combinational from state, valid_o and ready_i only.
//  Non-MUL: accepted at edge k -> valid_o=1 after edge k (latency 1).
//  MUL: accepted at edge k -> state MUL, counter = XLEN/MUL_STEP.
//   Each edge retires MUL_STEP bits and decrements the counter.
//   On the final step the result loads and valid_o=1 after edge k+XLEN/MUL_STEP; state returns to IDLE.
//   If the output is still occupied on the final step (valid_o & ~ready_i), hold the counter at 1 and retry each cycle.
//  Output hold: while valid_o & ~ready_i, result_o, zero_o and illegal_o are stable.
//   valid_o clears on the handshake unless a new result loads on the same edge.
//  Back-to-back: handshake out and accept in on the same edge is legal, giving 1 result per cycle for non-MUL ops.
//  Inputs are sampled only at acceptance. src/funct changes during MUL have no effect.
// STRUCTURE
//  Package alu_pkg: ALUOp codes, funct7/funct3 constants, alu_op_e enum, FSM state enum (IDLE, MUL).
//  Sub-module mul_iter (XLEN, MUL_STEP): start/busy/done shift-add multiplier, low product only.
//  Decode, 1-cycle ALU and output register stay in this module.
// TESTING
//  1. rst_i high 2 cycles with valid_i=1 -> all outputs 0, ready_o=1; no op accepted.
//  2. ALUOp=10, funct=0100000_000, A=5, B=7 -> next cycle result=32'hFFFFFFFE, zero=0.
//     Same op with ALUOp=01, A=B=9 -> result=0, zero=1.
//  3. ALUOp=11, funct=0100000_101, A=32'h80000000, B=4 -> result=32'hF8000000.
//     funct7=0000000 instead -> 32'h08000000.
//  4. MUL A=32'hFFFFFFFF, B=3, ready_i=1 -> ready_o=0 for 32 cycles, valid_o after edge k+32 with result=32'hFFFFFFFD.
//     Repeat with MUL_STEP=4 -> 8 cycles.
//  5. ALUOp=10, funct=1111111_000 -> illegal_o=1, result=0, latency 1. Next legal op clears illegal_o.
//  6. ready_i=0 for 5 cycles after an ADD result -> outputs stable, ready_o=0.
//     Reset asserted mid-MUL -> valid_o=0 and IDLE next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the EX-stage ALU: ALUOp codes, funct fields,
// the internal operation enum, the stage FSM states and the decode function.
package alu_pkg;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_SLL     = 4'd2,
    OP_SLT     = 4'd3,
    OP_SLTU    = 4'd4,
    OP_XOR     = 4'd5,
    OP_SRL     = 4'd6,
    OP_SRA     = 4'd7,
    OP_OR      = 4'd8,
    OP_AND     = 4'd9,
    OP_MUL     = 4'd10,
    OP_ILLEGAL = 4'd11
  } alu_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } exec_state_e;

  // Map {ALUOp, funct7, funct3} onto an internal operation; anything unlisted is illegal.
  function automatic alu_op_e decode_op(input logic [1:0] alu_op, input logic [9:0] funct);
    logic [6:0] f7;
    logic [2:0] f3;
    alu_op_e    op;
    f7 = funct[9:3];
    f3 = funct[2:0];
    op = OP_ILLEGAL;
    case (alu_op)
      ALUOP_LDST:   op = OP_ADD;
      ALUOP_BRANCH: op = OP_SUB;
      ALUOP_RTYPE: begin
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD:  op = OP_ADD;
            F3_SLL:  op = OP_SLL;
            F3_SLT:  op = OP_SLT;
            F3_SLTU: op = OP_SLTU;
            F3_XOR:  op = OP_XOR;
            F3_SR:   op = OP_SRL;
            F3_OR:   op = OP_OR;
            F3_AND:  op = OP_AND;
            default: op = OP_ILLEGAL;
          endcase
        end else if ((f7 == F7_ALT) && (f3 == F3_ADD)) begin
          op = OP_SUB;
        end else if ((f7 == F7_ALT) && (f3 == F3_SR)) begin
          op = OP_SRA;
        end else if ((f7 == F7_MULDIV) && (f3 == F3_ADD)) begin
          op = OP_MUL;
        end else begin
          op = OP_ILLEGAL;
        end
      end
      ALUOP_ITYPE: begin
        case (f3)
          F3_ADD:  op = OP_ADD;
          F3_SLT:  op = OP_SLT;
          F3_SLTU: op = OP_SLTU;
          F3_XOR:  op = OP_XOR;
          F3_OR:   op = OP_OR;
          F3_AND:  op = OP_AND;
          F3_SLL:  op = (f7 == F7_BASE) ? OP_SLL : OP_ILLEGAL;
          F3_SR: begin
            if (f7 == F7_BASE) begin
              op = OP_SRL;
            end else if (f7 == F7_ALT) begin
              op = OP_SRA;
            end else begin
              op = OP_ILLEGAL;
            end
          end
          default: op = OP_ILLEGAL;
        endcase
      end
      default: op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier producing the low XLEN bits of a*b,
// retiring MUL_STEP multiplier bits per cycle. The last step can be held off.
module mul_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            hold_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  localparam int STEPS = XLEN / MUL_STEP;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [XLEN-1:0]  partial_s;
  logic             last_s;
  logic             advance_s;

  // Partial product of the MUL_STEP multiplier bits currently at the bottom of mplier_q.
  always_comb begin
    partial_s = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier_q[j]) begin
        partial_s = partial_s + (mcand_q << j);
      end else begin
        partial_s = partial_s;
      end
    end
  end

  // The final step stalls (counter stays at 1) while the consumer still holds a result.
  assign last_s    = busy_q && (cnt_q == CNT_ONE);
  assign advance_s = busy_q && !(last_s && hold_i);
  assign done_o    = advance_s && last_s;
  assign busy_o    = busy_q;
  assign product_o = acc_q + partial_s;

  // Next-state for the accumulator, shifted operands and step counter.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
      cnt_d    = CNT_INIT;
      busy_d   = 1'b1;
    end else if (advance_s) begin
      acc_d    = acc_q + partial_s;
      mcand_d  = mcand_q << MUL_STEP;
      mplier_d = mplier_q >> MUL_STEP;
      cnt_d    = cnt_q - CNT_ONE;
      busy_d   = !last_s;
    end else begin
      busy_d   = busy_q;
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// RV32 EX stage: decodes {funct7,funct3} under ALUOp, executes single-cycle ops
// directly and MUL on mul_iter, presenting a registered valid/ready result.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      ALUOp_i,
  input  logic [9:0]      funct_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_o
);

  localparam int SH_W = $clog2(XLEN);

  exec_state_e     state_q, state_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  alu_op_e         op_s;
  logic            accept_s;
  logic            out_fire_s;
  logic            mul_start_s;
  logic            mul_busy_s;
  logic            mul_done_s;
  logic [XLEN-1:0] mul_product_s;
  logic [XLEN-1:0] alu_res_s;
  logic [SH_W-1:0] shamt_s;

  assign ready_o     = (state_q == ST_IDLE) && (!valid_q || ready_i);
  assign accept_s    = valid_i && ready_o;
  assign out_fire_s  = valid_q && ready_i;
  assign op_s        = decode_op(ALUOp_i, funct_i);
  assign mul_start_s = accept_s && (op_s == OP_MUL);
  assign shamt_s     = src2_i[SH_W-1:0];

  mul_iter #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start_s),
    .hold_i    (valid_q && !ready_i),
    .a_i       (src1_i),
    .b_i       (src2_i),
    .busy_o    (mul_busy_s),
    .done_o    (mul_done_s),
    .product_o (mul_product_s)
  );

  // Single-cycle datapath; MUL and illegal ops produce zero here.
  always_comb begin
    alu_res_s = '0;
    case (op_s)
      OP_ADD:  alu_res_s = src1_i + src2_i;
      OP_SUB:  alu_res_s = src1_i - src2_i;
      OP_SLL:  alu_res_s = src1_i << shamt_s;
      OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (src1_i < src2_i)};
      OP_XOR:  alu_res_s = src1_i ^ src2_i;
      OP_SRL:  alu_res_s = src1_i >> shamt_s;
      OP_SRA:  alu_res_s = $unsigned($signed(src1_i) >>> shamt_s);
      OP_OR:   alu_res_s = src1_i | src2_i;
      OP_AND:  alu_res_s = src1_i & src2_i;
      default: alu_res_s = '0;
    endcase
  end

  // FSM and output register next-state.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_IDLE: state_d = mul_start_s ? ST_MUL : ST_IDLE;
      // A multiplier that is no longer busy without finishing returns us to IDLE.
      ST_MUL:  state_d = (mul_done_s || !mul_busy_s) ? ST_IDLE : ST_MUL;
      default: state_d = ST_IDLE;
    endcase

    if (mul_done_s) begin
      valid_d   = 1'b1;
      result_d  = mul_product_s;
      zero_d    = (mul_product_s == '0);
      illegal_d = 1'b0;
    end else if (accept_s && (op_s != OP_MUL)) begin
      valid_d   = 1'b1;
      result_d  = alu_res_s;
      zero_d    = (alu_res_s == '0);
      illegal_d = (op_s == OP_ILLEGAL);
    end else if (out_fire_s) begin
      valid_d   = 1'b0;
    end else begin
      valid_d   = valid_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, hand-written handshake/reset
// sequences and a randomized scoreboard run against a behavioural model.
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_i;
  logic            ready_i;
  logic [1:0]      aluop;
  logic [9:0]      funct;
  logic [XLEN-1:0] a, b;

  logic            ready_o, valid_o, zero_o, illegal_o;
  logic [XLEN-1:0] result_o;
  logic            ready4, valid4, zero4, illegal4;
  logic [XLEN-1:0] result4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(XLEN), .MUL_STEP(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .ALUOp_i(aluop), .funct_i(funct), .src1_i(a), .src2_i(b),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .zero_o(zero_o), .illegal_o(illegal_o)
  );

  alu_exec_unit #(.XLEN(XLEN), .MUL_STEP(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready4),
    .ALUOp_i(aluop), .funct_i(funct), .src1_i(a), .src2_i(b),
    .valid_o(valid4), .ready_i(ready_i), .result_o(result4),
    .zero_o(zero4), .illegal_o(illegal4)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        ill;
    logic [31:0] r;
  } ref_t;

  // Base integer ops selected by funct3 (shared by R and I forms).
  function automatic logic [31:0] base_op(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    int sh;
    sh = int'(y % 32);
    case (f3)
      3'd0:    return x + y;
      3'd1:    return x << sh;
      3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3:    return (x < y) ? 32'd1 : 32'd0;
      3'd4:    return x ^ y;
      3'd5:    return x >> sh;
      3'd6:    return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic ref_t model(input logic [1:0] op, input logic [9:0] f, input logic [31:0] x, input logic [31:0] y);
    ref_t o;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [31:0] sra;
    f7 = f[9:3];
    f3 = f[2:0];
    sra = $unsigned($signed(x) >>> (y % 32));
    o.ill = 1'b0;
    o.r = 32'd0;
    case (op)
      2'd0: o.r = x + y;
      2'd1: o.r = x - y;
      2'd2: begin
        if (f7 == 7'h00) o.r = base_op(f3, x, y);
        else if (f7 == 7'h20 && f3 == 3'd0) o.r = x - y;
        else if (f7 == 7'h20 && f3 == 3'd5) o.r = sra;
        else if (f7 == 7'h01 && f3 == 3'd0) o.r = x * y;
        else o.ill = 1'b1;
      end
      default: begin
        if (f3 == 3'd1 && f7 != 7'h00) o.ill = 1'b1;
        else if (f3 == 3'd5 && f7 == 7'h20) o.r = sra;
        else if (f3 == 3'd5 && f7 != 7'h00) o.ill = 1'b1;
        else o.r = base_op(f3, x, y);
      end
    endcase
    return o;
  endfunction

  typedef struct {
    logic [1:0]  aluop;
    logic [9:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    logic        exp_z;
    logic        exp_ill;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [31:0] x, input logic [31:0] y, input logic [31:0] r,
                      input logic z, input logic ill, input int lat);
    vec_t v;
    v.aluop = op; v.funct = {f7, f3}; v.a = x; v.b = y;
    v.exp_r = r; v.exp_z = z; v.exp_ill = ill; v.exp_lat = lat;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] pool[16];
  ref_t       sb[$];

  initial begin
    int n, busy, lat4;
    logic seen4;
    logic [31:0] res4;
    logic stall_prev;
    logic [31:0] held_r;
    logic held_z, held_ill;
    ref_t e;

    rst = 1'b1; valid_i = 1'b1; ready_i = 1'b1;
    aluop = 2'b00; funct = 10'd0; a = 32'd1; b = 32'd1;

    // Reset held with a request pending: nothing is accepted.
    tick(); tick();
    check1("rst_valid", valid_o, 1'b0);
    check32("rst_result", result_o, 32'd0);
    check1("rst_zero", zero_o, 1'b0);
    check1("rst_illegal", illegal_o, 1'b0);
    check1("rst_ready", ready_o, 1'b1);
    valid_i = 1'b0; rst = 1'b0;
    tick();
    check1("post_rst_valid", valid_o, 1'b0);

    addv(2'b10, 7'b0100000, 3'b000, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 0);
    addv(2'b01, 7'b1111111, 3'b111, 32'd9, 32'd9, 32'h0, 1'b1, 1'b0, 0);
    addv(2'b11, 7'b0100000, 3'b101, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0, 0);
    addv(2'b11, 7'b0000000, 3'b101, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1'b0, 0);
    addv(2'b10, 7'b1111111, 3'b000, 32'd12, 32'd34, 32'h0, 1'b1, 1'b1, 0);
    addv(2'b00, 7'b0101010, 3'b101, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b1, 1'b0, 0);
    addv(2'b10, 7'b0000000, 3'b010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 0);
    addv(2'b10, 7'b0000000, 3'b011, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 0);
    addv(2'b10, 7'b0000000, 3'b001, 32'd1, 32'h0000003F, 32'h80000000, 1'b0, 1'b0, 0);
    addv(2'b10, 7'b0000000, 3'b001, 32'd1, 32'h00000020, 32'd1, 1'b0, 1'b0, 0);
    addv(2'b11, 7'b0100000, 3'b001, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1, 0);
    addv(2'b10, 7'b0000001, 3'b000, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 1'b0, 1'b0, 32);
    addv(2'b10, 7'b0000001, 3'b001, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1, 0);
    addv(2'b11, 7'b1010101, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 0);
    addv(2'b11, 7'b0000000, 3'b010, 32'h80000000, 32'd0, 32'd1, 1'b0, 1'b0, 0);
    addv(2'b10, 7'b0000000, 3'b101, 32'h80000000, 32'd31, 32'd1, 1'b0, 1'b0, 0);
    addv(2'b10, 7'b0000000, 3'b110, 32'h0F0F0000, 32'h0000F0F0, 32'h0F0FF0F0, 1'b0, 1'b0, 0);
    addv(2'b10, 7'b0000000, 3'b111, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0, 0);
    addv(2'b10, 7'b0000001, 3'b000, 32'h00010000, 32'h00010000, 32'h0, 1'b1, 1'b0, 32);
    addv(2'b11, 7'b0000000, 3'b000, 32'd7, 32'hFFFFFFFF, 32'd6, 1'b0, 1'b0, 0);

    foreach (vecs[i]) begin
      check1($sformatf("v%0d_ready", i), ready_o, 1'b1);
      aluop = vecs[i].aluop; funct = vecs[i].funct; a = vecs[i].a; b = vecs[i].b;
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      n = 0; busy = 0; seen4 = 1'b0; lat4 = -1; res4 = 32'd0;
      while (!valid_o && n < 200) begin
        if (!ready_o) busy++;
        if (!seen4 && valid4) begin seen4 = 1'b1; lat4 = n; res4 = result4; end
        a = $urandom; b = $urandom; funct = 10'($urandom);
        tick();
        n++;
      end
      if (!seen4 && valid4) begin seen4 = 1'b1; lat4 = n; res4 = result4; end
      checki($sformatf("v%0d_latency", i), n, vecs[i].exp_lat);
      checki($sformatf("v%0d_busy_cycles", i), busy, vecs[i].exp_lat);
      check32($sformatf("v%0d_result", i), result_o, vecs[i].exp_r);
      check1($sformatf("v%0d_zero", i), zero_o, vecs[i].exp_z);
      check1($sformatf("v%0d_illegal", i), illegal_o, vecs[i].exp_ill);
      checki($sformatf("v%0d_step4_latency", i), lat4, (vecs[i].exp_lat == 0) ? 0 : 8);
      check32($sformatf("v%0d_step4_result", i), res4, vecs[i].exp_r);
    end
    tick();

    // Output stall: result must hold and ready_o stays low.
    ready_i = 1'b0;
    aluop = 2'b00; funct = 10'd0; a = 32'd100; b = 32'd23; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    check1("stall_valid", valid_o, 1'b1);
    check32("stall_result", result_o, 32'd123);
    for (int k = 0; k < 5; k++) begin
      a = $urandom; b = $urandom;
      tick();
      check1("stall_ready_low", ready_o, 1'b0);
      check1("stall_valid_hold", valid_o, 1'b1);
      check32("stall_result_hold", result_o, 32'd123);
      check1("stall_zero_hold", zero_o, 1'b0);
    end
    ready_i = 1'b1;
    #1;
    check1("stall_release_ready", ready_o, 1'b1);
    tick();
    check1("stall_drained", valid_o, 1'b0);

    // Back-to-back single-cycle ops, one result per cycle.
    begin
      logic [1:0]  bop[3];
      logic [9:0]  bf[3];
      logic [31:0] ba[3], bb[3], br[3];
      bop[0] = 2'b00; bf[0] = 10'd0;                  ba[0] = 32'd1; bb[0] = 32'd2; br[0] = 32'd3;
      bop[1] = 2'b01; bf[1] = 10'd0;                  ba[1] = 32'd3; bb[1] = 32'd3; br[1] = 32'd0;
      bop[2] = 2'b10; bf[2] = {7'b0000000, 3'b100};   ba[2] = 32'd5; bb[2] = 32'd3; br[2] = 32'd6;
      for (int k = 0; k < 3; k++) begin
        check1("b2b_ready", ready_o, 1'b1);
        aluop = bop[k]; funct = bf[k]; a = ba[k]; b = bb[k]; valid_i = 1'b1;
        tick();
        check1("b2b_valid", valid_o, 1'b1);
        check32("b2b_result", result_o, br[k]);
      end
      valid_i = 1'b0;
      tick();
      check1("b2b_drained", valid_o, 1'b0);
    end

    // MUL result arriving into a stalled consumer is held.
    ready_i = 1'b0;
    aluop = 2'b10; funct = {7'b0000001, 3'b000}; a = 32'd7; b = 32'd6; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 100) begin tick(); n++; end
    checki("mulstall_latency", n, 32);
    for (int k = 0; k < 3; k++) begin
      check32("mulstall_hold", result_o, 32'd42);
      tick();
    end
    ready_i = 1'b1;
    tick();
    check1("mulstall_drained", valid_o, 1'b0);

    // Reset in the middle of a MUL abandons it.
    aluop = 2'b10; funct = {7'b0000001, 3'b000}; a = 32'd3; b = 32'd3; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check1("midmul_busy", ready_o, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1("midmul_rst_valid", valid_o, 1'b0);
    check1("midmul_rst_ready", ready_o, 1'b1);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (valid_o) n++;
      tick();
    end
    checki("midmul_no_result", n, 0);

    // Randomized traffic with scoreboard.
    pool[0]  = {7'h00, 3'd0}; pool[1]  = {7'h00, 3'd1}; pool[2]  = {7'h00, 3'd2};
    pool[3]  = {7'h00, 3'd3}; pool[4]  = {7'h00, 3'd4}; pool[5]  = {7'h00, 3'd5};
    pool[6]  = {7'h00, 3'd6}; pool[7]  = {7'h00, 3'd7}; pool[8]  = {7'h20, 3'd0};
    pool[9]  = {7'h20, 3'd5}; pool[10] = {7'h01, 3'd0}; pool[11] = {7'h20, 3'd1};
    pool[12] = {7'h01, 3'd5}; pool[13] = {7'h55, 3'd4}; pool[14] = {7'h20, 3'd2};
    pool[15] = {7'h7F, 3'd0};
    stall_prev = 1'b0; held_r = 32'd0; held_z = 1'b0; held_ill = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (stall_prev) begin
        check1("rand_hold_valid", valid_o, 1'b1);
        check32("rand_hold_result", result_o, held_r);
        check1("rand_hold_zero", zero_o, held_z);
        check1("rand_hold_illegal", illegal_o, held_ill);
      end
      ready_i = ($urandom_range(0, 3) != 0);
      valid_i = 1'($urandom_range(0, 1));
      aluop = 2'($urandom_range(0, 3));
      funct = ($urandom_range(0, 4) == 0) ? 10'($urandom) : pool[$urandom_range(0, 15)];
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      #1;
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          checki("rand_unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check32("rand_result", result_o, e.r);
          check1("rand_zero", zero_o, (e.r == 32'd0));
          check1("rand_illegal", illegal_o, e.ill);
        end
      end
      if (valid_i && ready_o) sb.push_back(model(aluop, funct, a, b));
      stall_prev = valid_o && !ready_i;
      held_r = result_o; held_z = zero_o; held_ill = illegal_o;
      tick();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      if (valid_o) begin
        e = sb.pop_front();
        check32("drain_result", result_o, e.r);
        check1("drain_illegal", illegal_o, e.ill);
      end
      tick();
      n++;
    end
    checki("drain_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
